// File: rtl/draw_bus_plot_fifo.sv
// draw_bus_plot_fifo: buffers draw-bus beats, converts colour, drains them to the VGA plot handshake.
// Optional PIXEL_CLIP_EN: discards off-screen beats before the FIFO and counts them as drops.
module draw_bus_plot_fifo #(
   parameter int DEPTH       = 16,
   parameter int COLOUR_BITS = 9,
   parameter int SCREEN_W    = 160,
   parameter int SCREEN_H    = 120
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [7:0]                bus_x,
   input  logic [7:0]                bus_y,
   input  logic [23:0]               bus_rgb,
   input  logic                      bus_draw_enable,
   input  logic                      clear_flags,
   output logic [7:0]                plot_x,
   output logic [7:0]                plot_y,
   output logic [COLOUR_BITS-1:0]    plot_colour,
   output logic                      plot_valid,
   input  logic                      plot_ready,
   output logic [$clog2(DEPTH):0]    fill_level,
   output logic                      overflow,
   output logic [7:0]                drop_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int K  = COLOUR_BITS / 3;
   logic [7:0]             mem_x [DEPTH];
   logic [7:0]             mem_y [DEPTH];
   logic [COLOUR_BITS-1:0] mem_c [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] fill_q, fill_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    drop_q, drop_d;
   logic          beat, clipped, accept, full, empty, push, pop, drop_ovf, drop;
   logic [COLOUR_BITS-1:0] colour;
   logic          unused_rgb_bits;
   assign unused_rgb_bits = ^bus_rgb;
`ifdef PIXEL_CLIP_EN
   localparam logic [8:0] SW = 9'(SCREEN_W);
   localparam logic [8:0] SH = 9'(SCREEN_H);
   assign clipped = beat && ({1'b0, bus_x} >= SW || {1'b0, bus_y} >= SH);
`else
   localparam int unused_geom = SCREEN_W + SCREEN_H;
   assign clipped = 1'b0;
`endif
   always_comb begin
      beat       = bus_draw_enable == 1'b1;
      accept     = beat && !clipped;
      full       = fill_q == LW'(DEPTH);
      empty      = fill_q == '0;
      pop        = !empty && plot_ready;
      push       = accept && (!full || pop);
      drop_ovf   = accept && full && !pop;
      drop       = drop_ovf || clipped;
      colour     = {bus_rgb[23 -: K], bus_rgb[15 -: K], bus_rgb[7 -: K]};
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      fill_d     = fill_q + LW'(push) - LW'(pop);
      overflow_d = clear_flags ? 1'b0 : overflow_q || drop_ovf;
      drop_d     = clear_flags ? 8'd0 : (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end
   // Storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_x[wr_ptr_q] <= bus_x;
         mem_y[wr_ptr_q] <= bus_y;
         mem_c[wr_ptr_q] <= colour;
      end
   end
   always_comb begin
      plot_valid  = !empty;
      plot_x      = empty ? 8'd0 : mem_x[rd_ptr_q];
      plot_y      = empty ? 8'd0 : mem_y[rd_ptr_q];
      plot_colour = empty ? '0 : mem_c[rd_ptr_q];
      fill_level  = fill_q;
      overflow    = overflow_q;
      drop_count  = drop_q;
   end
endmodule

// File: tb/tb_draw_bus_plot_fifo.sv
// tb_draw_bus_plot_fifo: directed checks of draw_bus_plot_fifo (DEPTH=16, COLOUR_BITS=9).
// Build with PIXEL_CLIP_EN defined to also exercise off-screen clipping.
module tb_draw_bus_plot_fifo;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  bus_x = '0, bus_y = '0;
   logic [23:0] bus_rgb = '0;
   logic        de_oe = 1'b0, de_drv = 1'b0;
   wire         bus_draw_enable;
   logic        clear_flags = 1'b0, plot_ready = 1'b0;
   logic [7:0]  plot_x, plot_y, drop_count;
   logic [8:0]  plot_colour;
   logic        plot_valid, overflow;
   logic [4:0]  fill_level;
   int          n_checks = 0, n_fail = 0;
   assign bus_draw_enable = de_oe ? de_drv : 1'bz;
   pulldown (bus_draw_enable);
   always #5 clk = ~clk;
   draw_bus_plot_fifo #(.DEPTH(16), .COLOUR_BITS(9), .SCREEN_W(160), .SCREEN_H(120)) dut (
      .clk(clk), .reset(reset), .bus_x(bus_x), .bus_y(bus_y), .bus_rgb(bus_rgb),
      .bus_draw_enable(bus_draw_enable), .clear_flags(clear_flags),
      .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour), .plot_valid(plot_valid),
      .plot_ready(plot_ready), .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [23:0] rgb);
      bus_x = x; bus_y = y; bus_rgb = rgb; de_drv = 1'b1; de_oe = 1'b1;
      @(posedge clk); #1;
      de_oe = 1'b0;
   endtask
   task automatic tick();
      @(posedge clk); #1;
   endtask
   initial begin
      repeat (2) tick();
      reset = 1'b0;
      repeat (20) tick();
      check("idle_valid", plot_valid, 0);
      check("idle_fill", fill_level, 0);
      check("idle_drop", drop_count, 0);
      check("idle_ovf", overflow, 0);
      check("idle_x", plot_x, 0);
      plot_ready = 1'b1;
      send(8'd5, 8'd7, 24'hFF8000);
      check("single_valid", plot_valid, 1);
      check("single_x", plot_x, 5);
      check("single_y", plot_y, 7);
      check("single_colour", plot_colour, 9'b111_100_000);
      tick();
      check("single_gone", plot_valid, 0);
      check("single_fill", fill_level, 0);
      plot_ready = 1'b0;
      for (int i = 0; i < 20; i++) send(8'(i), 8'(i + 100), 24'h000000);
      check("burst_fill", fill_level, 16);
      check("burst_ovf", overflow, 1);
      check("burst_drop", drop_count, 4);
      repeat (2) tick();
      check("stall_hold_x", plot_x, 0);
      check("stall_hold_y", plot_y, 100);
      plot_ready = 1'b1;
      send(8'd99, 8'd98, 24'h20E0A0);
      check("pp_fill", fill_level, 16);
      check("pp_drop", drop_count, 4);
      for (int k = 1; k < 16; k++) begin
         check("drain_x", plot_x, k);
         check("drain_y", plot_y, k + 100);
         tick();
      end
      check("last_x", plot_x, 99);
      check("last_colour", plot_colour, 9'b001_111_101);
      tick();
      check("drained", plot_valid, 0);
      clear_flags = 1'b1; tick(); clear_flags = 1'b0;
      check("clr_ovf", overflow, 0);
      check("clr_drop", drop_count, 0);
      plot_ready = 1'b0;
      for (int i = 0; i < 316; i++) send(8'(i), 8'd1, 24'h0);
      check("sat_drop", drop_count, 255);
      check("sat_ovf", overflow, 1);
      check("sat_fill", fill_level, 16);
      clear_flags = 1'b1;
      send(8'd200, 8'd1, 24'h0);
      clear_flags = 1'b0;
      check("clrwin_ovf", overflow, 0);
      check("clrwin_drop", drop_count, 0);
      check("clrwin_fill", fill_level, 16);
      check("clrwin_head", plot_x, 0);
      reset = 1'b1; tick(); reset = 1'b0;
      check("rst_fill", fill_level, 0);
      check("rst_valid", plot_valid, 0);
`ifdef PIXEL_CLIP_EN
      send(8'd160, 8'd0, 24'h0);
      send(8'd0, 8'd120, 24'h0);
      send(8'd159, 8'd119, 24'hFFFFFF);
      check("clip_fill", fill_level, 1);
      check("clip_drop", drop_count, 2);
      check("clip_ovf", overflow, 0);
      check("clip_x", plot_x, 159);
      check("clip_y", plot_y, 119);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/draw_bus_plot_fifo.md
Name: draw_bus_plot_fifo

Overview:
- Downstream consumer of the shared pixel draw bus driven by the screen-clear and tile-drawing FSMs.
- Captures every asserted draw-bus beat, converts 24-bit RGB to the VGA adapter colour width, and buffers it in a FIFO.
- Drains the FIFO to the VGA adapter plot interface under a valid/ready handshake, so bursts from the drawers are absorbed without loss until the FIFO is full.
- Overflow and clip drops are reported to the game controller.

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 2.
- COLOUR_BITS, 9: plot_colour width; multiple of 3, at most 24.
- SCREEN_W, 160: visible width in pixels; only used when PIXEL_CLIP_EN is defined.
- SCREEN_H, 120: visible height in pixels; only used when PIXEL_CLIP_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- bus_x  input  8  draw-bus x coordinate.
- bus_y  input  8  draw-bus y coordinate.
- bus_rgb  input  24  draw-bus colour, {R[23:16], G[15:8], B[7:0]}.
- bus_draw_enable  input  1  draw-bus strobe; one beat per cycle it is 1. Floats to z when no drawer owns the bus.
- clear_flags  input  1  one-cycle pulse; clears overflow and drop_count.
- plot_x  output  8  head-entry x.
- plot_y  output  8  head-entry y.
- plot_colour  output  COLOUR_BITS  head-entry colour.
- plot_valid  output  1  FIFO not empty.
- plot_ready  input  1  adapter accepts the head entry. Tie to 1 for the unstalled vga_adapter.
- fill_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; a beat was lost because the FIFO was full.
- drop_count  output  8  saturating count of discarded beats.

Behaviour:
- Reset (synchronous, active-high): on any rising clk with reset=1, the block enters its reset state.
  - FIFO emptied; read and write pointers = 0.
  - plot_valid=0, fill_level=0, overflow=0, drop_count=0.
  - plot_x, plot_y, plot_colour = 0.
  - Beats present during reset are discarded and not counted. A reset mid-burst loses all buffered entries.
- Bus sampling:
  - A beat is present when bus_draw_enable is logic 1.
  - z or 0 means no beat. The bench holds a weak pull-down on the bus.
- Colour conversion: with k = COLOUR_BITS/3, plot_colour = {R[23:24-k], G[15:16-k], B[7:8-k]}. Pure truncation, no rounding.
- Push: a present, unclipped beat is written at the write pointer when not full.
  - If full and no pop in the same cycle: the beat is dropped, overflow is set to 1, and drop_count increments.
- Pop: on a rising edge with plot_valid=1 and plot_ready=1, the head entry is consumed.
  - plot_ready is ignored while empty.
- Simultaneous push and pop:
  - Accepted even when full; fill_level is unchanged.
  - When empty, the push is accepted and the pop does not occur.
- Latency:
  - A beat accepted at edge N is visible on the plot outputs after edge N, provided the FIFO was empty. plot_valid=1 from that edge on.
  - The write path has no combinational bypass.
- Output stability: plot_x, plot_y and plot_colour are held while plot_valid=1 and plot_ready=0.
- Pointers: log2(DEPTH) bits, wrapping naturally. full = (fill_level==DEPTH), empty = (fill_level==0).
- drop_count saturates at 255 and never wraps.
- clear_flags:
  - Zeroes overflow and drop_count on the next edge. FIFO contents are untouched.
  - If a drop occurs in the same cycle, clear wins: overflow=0, count=0.
- Order: entries leave in exactly the order they were accepted.

Optional Feature:
- Macro: PIXEL_CLIP_EN.
- Defined: a present beat with bus_x >= SCREEN_W or bus_y >= SCREEN_H is discarded before the FIFO.
  - It increments drop_count (saturating).
  - It does not set overflow.
- Undefined: all present beats are pushed unchanged. SCREEN_W and SCREEN_H are unused.

Test Plan:
- Reset then idle, with bus_draw_enable at z for 20 cycles -> plot_valid=0, fill_level=0, drop_count=0.
- Single beat x=5, y=7, rgb=24'hFF8000 with COLOUR_BITS=9, plot_ready=1 -> one cycle later plot_x=5, plot_y=7, plot_colour=9'b111_100_000, plot_valid=1 for exactly one cycle.
- plot_ready=0 with a 20-beat burst (x=0..19), DEPTH=16 -> fill_level=16, overflow=1, drop_count=4. Then plot_ready=1 -> x=0..15 emerge in order.
- FIFO full, push and pop in the same cycle -> fill_level stays 16, no drop, and the new beat appears last.
- Define PIXEL_CLIP_EN and send x=160,y=0; x=0,y=120; x=159,y=119 -> only (159,119) emerges, drop_count=2, overflow=0.
- overflow=1 with drop_count=255 after 300 drops, then a clear_flags pulse -> next cycle overflow=0, drop_count=0, FIFO contents retained.
